fp_multiplier: RTL and testbench

Sequential IEEE-754 single-precision multiplier, the inverse operation to the team's divider, sharing the same operand/control/result convention so both units can sit side by side behind the arithmetic unit's operation select. Operands are captured on a `control` strobe. The 24×24 significand product is formed by an iterative radix-2 shift-add datapath, then normalised and rounded to nearest-even. The result is presented on `out` with a one-cycle `done` pulse and exception flags.

---
 rtl/fp_pkg.sv | 23 ++
 rtl/fp_classify.sv | 29 ++
 rtl/fp_multiplier.sv | 185 ++++++++++++++++++
 tb/tb_fp_multiplier.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared binary32 field layout, constants and state encoding for the
// sequential floating-point multiply/divide units.
package fp_pkg;

    localparam int SIGN_W  = 1;
    localparam int EXP_W   = 8;
    localparam int MANT_W  = 23;
    localparam int WORD_W  = SIGN_W + EXP_W + MANT_W;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [WORD_W-1:0] QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        MULT,
        NORM,
        ROUND,
        DONE
    } fp_state_e;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier for one binary32 value.
module fp_classify
    import fp_pkg::*;
(
    input  logic [WORD_W-1:0] op,
    output logic              is_zero,
    output logic              is_inf,
    output logic              is_nan,
    output logic              is_denorm
);

    logic [EXP_W-1:0]  exp_f;
    logic [MANT_W-1:0] mant_f;
    logic              exp_all1;
    logic              exp_all0;
    logic              mant_zero;

    assign exp_f     = op[WORD_W-2 -: EXP_W];
    assign mant_f    = op[MANT_W-1:0];
    assign exp_all1  = &exp_f;
    assign exp_all0  = ~|exp_f;
    assign mant_zero = ~|mant_f;

    assign is_zero   = exp_all0 &  mant_zero;
    assign is_denorm = exp_all0 & ~mant_zero;
    assign is_inf    = exp_all1 &  mant_zero;
    assign is_nan    = exp_all1 & ~mant_zero;

endmodule

// File: rtl/fp_multiplier.sv
// Sequential binary32 multiplier: radix-2 shift-add significand product,
// normalise, round-to-nearest-even, flush-to-zero on denormal inputs.
module fp_multiplier
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] MC,
    input  logic [WORD_W-1:0] MP,
    input  logic              control,
    output logic [WORD_W-1:0] out,
    output logic              done,
    output logic              busy,
    output logic              exception,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [4:0]        LAST_ITER = 5'd23;
    localparam logic signed [9:0] BIAS_E    = 10'(BIAS);
    localparam logic signed [9:0] EXP_TOP   = 10'(EXP_MAX);

    fp_state_e state, state_nxt;

    logic [WORD_W-1:0]    mc_q, mp_q;
    logic                 sign_q;
    logic signed [9:0]    exp_q;
    logic [MANT_W:0]      mcand_q;
    logic [2*MANT_W+1:0]  prod_q;
    logic [4:0]           cnt_q;
    logic [MANT_W-1:0]    mant_q;
    logic                 guard_q, sticky_q;

    logic mc_zero, mc_inf, mc_nan, mc_den;
    logic mp_zero, mp_inf, mp_nan, mp_den;

    fp_classify u_cls_mc (
        .op        (mc_q),
        .is_zero   (mc_zero),
        .is_inf    (mc_inf),
        .is_nan    (mc_nan),
        .is_denorm (mc_den)
    );

    fp_classify u_cls_mp (
        .op        (mp_q),
        .is_zero   (mp_zero),
        .is_inf    (mp_inf),
        .is_nan    (mp_nan),
        .is_denorm (mp_den)
    );

    function automatic logic [MANT_W:0] round_rne(input logic [MANT_W-1:0] mant,
                                                  input logic              guard,
                                                  input logic              sticky);
        logic up;
        up = guard & (sticky | mant[0]);
        return {1'b0, mant} + {{MANT_W{1'b0}}, up};
    endfunction

    logic              sign_w;
    logic              invalid_w, inf_w, zero_w, special_w;
    logic signed [9:0] ea_w, eb_w, exp_sum_w;
    logic [MANT_W+1:0] psum_w;
    logic [MANT_W:0]   rnd_w;
    logic signed [9:0] exp_rnd_w;

    always_comb begin
        sign_w    = mc_q[WORD_W-1] ^ mp_q[WORD_W-1];
        invalid_w = mc_nan | mp_nan | (mc_zero & mp_inf) | (mc_inf & mp_zero);
        inf_w     = mc_inf | mp_inf;
        zero_w    = mc_zero | mp_zero | mc_den | mp_den;
        special_w = invalid_w | inf_w | zero_w;
        ea_w      = $signed({2'b00, mc_q[WORD_W-2 -: EXP_W]});
        eb_w      = $signed({2'b00, mp_q[WORD_W-2 -: EXP_W]});
        exp_sum_w = ea_w + eb_w - BIAS_E;
        // Upper half plus multiplicand keeps its carry as the new MSB after the shift.
        psum_w    = {1'b0, prod_q[2*MANT_W+1:MANT_W+1]}
                    + ({2'b00, mcand_q} & {(MANT_W+2){prod_q[0]}});
        rnd_w     = round_rne(mant_q, guard_q, sticky_q);
        exp_rnd_w = exp_q + $signed({9'b0, rnd_w[MANT_W]});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (control) state_nxt = UNPACK;
            UNPACK:  state_nxt = special_w ? DONE : MULT;
            MULT:    if (cnt_q == LAST_ITER) state_nxt = NORM;
            NORM:    state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign done = (state == DONE);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mc_q      <= '0;
            mp_q      <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            mant_q    <= '0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            out       <= '0;
            exception <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                // capture
                IDLE: begin
                    if (control) begin
                        mc_q      <= MC;
                        mp_q      <= MP;
                        cnt_q     <= '0;
                        exception <= 1'b0;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                    end
                end
                // classify and short-circuit special operands
                UNPACK: begin
                    sign_q <= sign_w;
                    if (invalid_w) begin
                        out       <= QNAN;
                        exception <= 1'b1;
                    end else if (inf_w) begin
                        out <= {sign_w, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                    end else if (zero_w) begin
                        out <= {sign_w, {(WORD_W-1){1'b0}}};
                    end else begin
                        mcand_q <= {1'b1, mc_q[MANT_W-1:0]};
                        prod_q  <= {{(MANT_W+1){1'b0}}, 1'b1, mp_q[MANT_W-1:0]};
                        exp_q   <= exp_sum_w;
                    end
                end
                // one shift-add iteration per cycle
                MULT: begin
                    prod_q <= {psum_w, prod_q[MANT_W:1]};
                    cnt_q  <= cnt_q + 5'd1;
                end
                // normalise product to 1.xxx
                NORM: begin
                    if (prod_q[2*MANT_W+1]) begin
                        mant_q   <= prod_q[2*MANT_W:MANT_W+1];
                        guard_q  <= prod_q[MANT_W];
                        sticky_q <= |prod_q[MANT_W-1:0];
                        exp_q    <= exp_q + 10'sd1;
                    end else begin
                        mant_q   <= prod_q[2*MANT_W-1:MANT_W];
                        guard_q  <= prod_q[MANT_W-1];
                        sticky_q <= |prod_q[MANT_W-2:0];
                    end
                end
                // round, range-check, pack
                ROUND: begin
                    if (exp_rnd_w >= EXP_TOP) begin
                        out      <= {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                        overflow <= 1'b1;
                    end else if (exp_rnd_w <= 10'sd0) begin
                        out       <= {sign_q, {(WORD_W-1){1'b0}}};
                        underflow <= 1'b1;
                    end else begin
                        out <= {sign_q, exp_rnd_w[EXP_W-1:0], rnd_w[MANT_W-1:0]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_multiplier.sv
// Randomised scoreboard bench for fp_multiplier against an integer-arithmetic
// reference of binary32 multiply with flush-to-zero and round-to-nearest-even.
module tb_fp_multiplier;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] MC, MP;
    logic        control;
    logic [31:0] out;
    logic        done, busy, exception, overflow, underflow;

    fp_multiplier dut (
        .clk       (clk),
        .reset     (reset),
        .MC        (MC),
        .MP        (MP),
        .control   (control),
        .out       (out),
        .done      (done),
        .busy      (busy),
        .exception (exception),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic        ovf;
        logic        unf;
        int          done_cyc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t            r;
        logic            s;
        int              ea, eb, e, sh;
        logic [63:0]     m, q, rem, half;
        bit              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        r.res = 32'h0; r.exc = 1'b0; r.ovf = 1'b0; r.unf = 1'b0; r.done_cyc = 1;
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        nan_a  = (ea == 255) && (a[22:0] != 0);
        nan_b  = (eb == 255) && (b[22:0] != 0);
        inf_a  = (ea == 255) && (a[22:0] == 0);
        inf_b  = (eb == 255) && (b[22:0] == 0);
        zero_a = (ea == 0) && (a[22:0] == 0);
        zero_b = (eb == 0) && (b[22:0] == 0);
        if (nan_a || nan_b || (zero_a && inf_b) || (inf_a && zero_b)) begin
            r.res = 32'h7FC00000;
            r.exc = 1'b1;
        end else if (inf_a || inf_b) begin
            r.res = {s, 8'hFF, 23'h0};
        end else if (ea == 0 || eb == 0) begin
            r.res = {s, 31'h0};
        end else begin
            m  = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
            e  = ea + eb - 127;
            if (m >= (64'd1 << 47)) begin e++; sh = 24; end
            else sh = 23;
            q    = m >> sh;
            rem  = m & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
            if (e >= 255) begin
                r.res = {s, 8'hFF, 23'h0};
                r.ovf = 1'b1;
            end else if (e <= 0) begin
                r.res = {s, 31'h0};
                r.unf = 1'b1;
            end else begin
                r.res = {s, 8'(e), q[22:0]};
            end
            r.done_cyc = 27;
        end
        return r;
    endfunction

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("out", out, e.res);
                check("flags", {29'b0, exception, overflow, underflow}, {29'b0, e.exc, e.ovf, e.unf});
                check("done_edge", 32'(cyc), 32'(e.done_cyc));
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int pulse_at);
        exp_t e;
        int   waited;
        bit   seen;
        @(negedge clk);
        MC      = a;
        MP      = b;
        control = 1'b1;
        @(posedge clk);
        #1;
        control = 1'b0;
        MC      = $urandom;
        MP      = $urandom;
        e = model(a, b);
        e.done_cyc += cyc;
        sbq.push_back(e);
        check("busy_after_capture", {31'b0, busy}, 32'd1);
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 40) begin
            @(negedge clk);
            waited++;
            if (done === 1'b1) seen = 1'b1;
            else if (pulse_at != 0 && waited == pulse_at) control = 1'b1;
            else if (pulse_at != 0 && waited == pulse_at + 1) control = 1'b0;
        end
        control = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no done within 40 cycles for %h x %h", a, b);
        end else begin
            check("busy_in_done", {31'b0, busy}, 32'd1);
            @(negedge clk);
            check("done_single_pulse", {31'b0, done}, 32'd0);
            check("busy_released", {31'b0, busy}, 32'd0);
        end
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        int          k;
        v = $urandom;
        k = $urandom_range(0, 19);
        case (k)
            0: v[30:0] = 31'h0;
            1: v[30:0] = {8'hFF, 23'h0};
            2: begin v[30:23] = 8'hFF; if (v[22:0] == 0) v[0] = 1'b1; end
            3: begin v[30:23] = 8'h00; if (v[22:0] == 0) v[5] = 1'b1; end
            4, 5: v[30:23] = 8'($urandom_range(1, 254));
            6: v[22:0] = ($urandom_range(0, 1) == 1) ? 23'h7FFFFF : 23'h0;
            default: v[30:23] = 8'($urandom_range(64, 190));
        endcase
        if (k >= 6) v[30:23] = (v[30:23] == 8'h00 || v[30:23] == 8'hFF) ? 8'd127 : v[30:23];
        return v;
    endfunction

    initial begin
        int dones;
        reset   = 1'b1;
        control = 1'b0;
        MC      = 32'h0;
        MP      = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_out", out, 32'h0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_flags", {29'b0, exception, overflow, underflow}, 32'd0);
        reset = 1'b0;

        run_op(32'h40000000, 32'h40400000, 0);
        check("2x3", out, 32'h40C00000);
        run_op(32'h3FC00000, 32'hC0200000, 0);
        check("1.5x-2.5", out, 32'hC0700000);
        run_op(32'h00000000, 32'h7F800000, 0);
        check("0xinf", {out[31:0]}, 32'h7FC00000);
        check("0xinf_exc", {31'b0, exception}, 32'd1);
        run_op(32'hFFC00000, 32'h3F800000, 0);
        check("nanx1", out, 32'h7FC00000);
        run_op(32'h7F7FFFFF, 32'h40000000, 0);
        check("ovf_out", out, 32'h7F800000);
        check("ovf_flag", {31'b0, overflow}, 32'd1);
        run_op(32'h00800000, 32'h00800000, 0);
        check("unf_out", out, 32'h00000000);
        check("unf_flag", {31'b0, underflow}, 32'd1);
        run_op(32'h3F800001, 32'h3F800001, 6);
        check("rne_out", out, 32'h3F800002);

        // Abort an operation with reset at edge 10.
        @(negedge clk);
        MC = 32'h3F800000; MP = 32'h40000000; control = 1'b1;
        @(posedge clk);
        #1 control = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_out", out, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_flags", {29'b0, exception, overflow, underflow}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_op(32'h3F800000, 32'h3F800000, 0);
        check("1x1", out, 32'h3F800000);

        for (int i = 0; i < 150; i++) begin
            run_op(rnd_op(), rnd_op(), ($urandom_range(0, 3) == 0) ? $urandom_range(3, 20) : 0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
